// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- registered, opcode-driven ALU with a valid/ready input handshake.
//
// One operation is accepted at a time, when in_valid and in_ready are both high
// at a clock edge. Most ops finish one cycle later. The optional shift-add
// multiplier finishes WIDTH+1 cycles later. Results and flags are held until
// the next out_valid pulse.
//
// Build option:
//   SEQ_ALU_MUL_EN  when defined, op 3'b110 is the multi-cycle multiplier.
//                   When undefined, no multiplier state or accumulator is
//                   built, and op 3'b110 is treated as reserved.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   op/a/b valid this cycle
//   in_ready   high only in IDLE; a transfer happens on in_valid & in_ready
//   op         000 ADD, 001 SHL(b), 010 SHR(b), 011 AND, 100 OR, 101 CMP,
//              110 MUL, 111 reserved
//   a, b       operands
//   out_valid  one-cycle pulse: result and flags were updated
//   result     registered result
//   ovf        overflow flag, held with result
//   zero       result == 0, held with result
//   illegal    op was reserved (or MUL when the multiplier is not built)
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             zero,
    output logic             illegal
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SHL = 3'b001;
    localparam logic [2:0] OP_SHR = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

`ifdef SEQ_ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } state_t;
`endif

    state_t state;
    state_t state_next;

    logic accept;

    // Single-cycle datapath, evaluated on the live inputs and captured at the
    // accept edge. This is equivalent to registering a/b/op first, and it
    // gives the one-cycle latency without an extra operand stage.
    logic [WIDTH:0]   sum;
    logic [WIDTH+2:0] cmp_vec;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf;
    logic             sc_illegal;
    logic             start_mul;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    assign sum = {1'b0, a} + {1'b0, b};

    // The three compare bits are zero-extended through a wider vector, which
    // keeps the expression legal for WIDTH == 2, where only {eq, lt} survive.
    assign cmp_vec = {{WIDTH{1'b0}}, (a > b), (a == b), (a < b)};

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        sc_result  = '0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        start_mul  = 1'b0;
        case (op)
            OP_ADD: begin
                sc_result = sum[WIDTH-1:0];
                sc_ovf    = sum[WIDTH];
            end
            OP_SHL: begin
                sc_result = b << 1;
                sc_ovf    = b[WIDTH-1];
            end
            OP_SHR: sc_result = b >> 1;
            OP_AND: sc_result = a & b;
            OP_OR:  sc_result = a | b;
            OP_CMP: sc_result = cmp_vec[WIDTH-1:0];
            OP_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                start_mul  = 1'b1;
`else
                sc_illegal = 1'b1;
`endif
            end
            default: sc_illegal = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    // Shift-add multiplier: one bit of b is consumed per cycle. The
    // multiplicand is kept 2*WIDTH wide so its shifted copies never lose
    // bits that belong in the product.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_step;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // The final step's sum is taken straight from acc_next into the output
    // registers. This lets the last step and the move to DONE share one edge.
    // The MUL state therefore lasts exactly WIDTH cycles.
    assign last_step = (state == ST_MUL) && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept && start_mul) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (state == ST_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end
`endif

    // NOTE: sequential state is written with non-blocking assignments, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                    state_next = start_mul ? ST_MUL : ST_DONE;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            ST_MUL: begin
                if (last_step) begin
                    state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output registers change only when a result completes. They hold
    // otherwise. A reset during a multiply clears them and discards the
    // partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (accept && !start_mul) begin
            result  <= sc_result;
            ovf     <= sc_ovf;
            zero    <= (sc_result == '0);
            illegal <= sc_illegal;
        end
`ifdef SEQ_ALU_MUL_EN
        else if (last_step) begin
            result  <= acc_next[WIDTH-1:0];
            ovf     <= |acc_next[2*WIDTH-1:WIDTH];
            zero    <= (acc_next[WIDTH-1:0] == '0);
            illegal <= 1'b0;
        end
`endif
    end

endmodule
